// File: rtl/seg_scan_if.sv
// Bus between the 7-segment scan controller and its board side: control inputs,
// the shared decoder loop (bin out, seven back) and the registered display drive.
interface seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic [3:0]              bin;
    logic [6:0]              seven;
    logic [6:0]              seg;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_done;

    modport master (output en, load, value, seven, input bin, seg, an, frame_done);
    modport slave  (input en, load, value, seven, output bin, seg, an, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with guard blanking and frame-aligned
// double-buffered updates. Define SEG_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int SHOW_CYC  = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int MAXC = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int DW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW   = 4 * N_DIGITS;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [DW-1:0]       r_digit, w_digit_nxt;
    logic [VW-1:0]       r_disp, r_shadow;
    logic                r_pend;
    logic [N_DIGITS-1:0] r_an, w_an_nxt;
    logic [6:0]          r_seg, w_seg_nxt;
    logic                r_frame_done;
    logic                w_bnd, w_to_idle, w_blank;

    // bin follows the digit register, which already points at the next digit during GUARD
    assign bus.bin        = r_disp[{r_digit, 2'b00} +: 4];
    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
    assign w_to_idle      = (r_state != IDLE) && !bus.en;

`ifdef SEG_LEAD_ZERO_BLANK_EN
    assign w_blank = (r_digit != '0) && ((r_disp >> {r_digit, 2'b00}) == '0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        w_an_nxt    = '1;
        w_seg_nxt   = 7'h7F;
        w_bnd       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_nxt = GUARD;
                    w_cnt_nxt   = '0;
                    w_digit_nxt = '0;
                end
            end
            GUARD: begin
                if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = SHOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_state_nxt = GUARD;
                    w_cnt_nxt   = '0;
                    w_bnd       = (r_digit == DIG_LAST);
                    w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + DW'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_digit_nxt = '0;
            w_bnd       = 1'b0;
        end
        // digit is unchanged on entry to / within SHOW, so seven already matches it
        if (w_state_nxt == SHOW) begin
            w_an_nxt[w_digit_nxt] = 1'b0;
            w_seg_nxt             = w_blank ? 7'h7F : bus.seven;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_digit      <= '0;
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit      <= w_digit_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            // registered so the pulse coincides with the boundary cycle itself
            r_frame_done <= (w_state_nxt == SHOW) && (w_digit_nxt == DIG_LAST)
                            && (w_cnt_nxt == SHOW_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp   <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (bus.load) begin
                r_disp <= bus.value;
                r_pend <= 1'b0;
            end
        end else if (w_bnd || w_to_idle) begin
            if (bus.load) begin
                r_disp <= bus.value;
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_disp <= r_shadow;
                r_pend <= 1'b0;
            end
        end else if (bus.load) begin
            r_shadow <= bus.value;
            r_pend   <= 1'b1;
        end
    end
endmodule
